// File: rtl/uart_mult_ctrl.sv
// uart_mult_ctrl: takes operand byte pairs (A then B) from the UART receiver,
// multiplies them with an 8-cycle shift-add engine and returns the 16-bit
// product to the UART transmitter as two bytes, high byte first.
module uart_mult_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,  // 0 disables the WAIT_B timeout
    parameter int unsigned MULT_BITS      = 8          // fixed at 8
) (
    input  logic        clk_int,
    input  logic        uart_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [15:0] product,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun_err,
    output logic        timeout_err
);

    localparam int unsigned TW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0]    LAST_BIT  = 3'(MULT_BITS - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_B   = 3'd1;
    localparam logic [2:0] ST_MULT     = 3'd2;
    localparam logic [2:0] ST_HI_START = 3'd3;
    localparam logic [2:0] ST_HI_WAIT  = 3'd4;
    localparam logic [2:0] ST_LO_START = 3'd5;
    localparam logic [2:0] ST_LO_WAIT  = 3'd6;

    logic [2:0]    state;
    logic [7:0]    op_a;
    logic [7:0]    op_b;      // shifted right each MULT cycle, bit 0 is the current multiplier bit
    logic [15:0]   a_sh;      // A shifted left to align with the current bit
    logic [15:0]   acc;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          seen_low;  // tx_ready has dropped since our start pulse

    logic [15:0]   acc_next;
    logic [TW-1:0] tmo_next;
    logic          drop_byte;

    // Datapath helpers and transmitter-facing outputs.
    always_comb begin
        acc_next  = acc + (op_b[0] ? a_sh : 16'h0000);
        tmo_next  = tmo_cnt + TW'(1);
        busy      = (state != ST_IDLE);
        drop_byte = rx_valid && (state != ST_IDLE) && (state != ST_WAIT_B);
        // Start is gated by tx_ready so it can never fire while the transmitter is busy.
        tx_start  = tx_ready && ((state == ST_HI_START) || (state == ST_LO_START));
        case (state)
            ST_HI_START, ST_HI_WAIT: tx_data = product[15:8];
            ST_LO_START, ST_LO_WAIT: tx_data = product[7:0];
            default:                 tx_data = 8'h00;
        endcase
    end

    // Control FSM, multiplier and status registers.
    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            state        <= ST_IDLE;
            op_a         <= 8'h00;
            op_b         <= 8'h00;
            a_sh         <= 16'h0000;
            acc          <= 16'h0000;
            bit_cnt      <= 3'd0;
            tmo_cnt      <= '0;
            seen_low     <= 1'b0;
            product      <= 16'h0000;
            result_valid <= 1'b0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            if (drop_byte) begin
                overrun_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        op_a    <= rx_data;
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    // A byte arriving on the limit cycle wins over the timeout.
                    if (rx_valid) begin
                        op_b    <= rx_data;
                        a_sh    <= {8'h00, op_a};
                        acc     <= 16'h0000;
                        bit_cnt <= 3'd0;
                        state   <= ST_MULT;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        tmo_cnt <= tmo_next;
                        if (tmo_next == TMO_LIMIT) begin
                            timeout_err <= 1'b1;
                            op_a        <= 8'h00;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_MULT: begin
                    acc     <= acc_next;
                    a_sh    <= {a_sh[14:0], 1'b0};
                    op_b    <= {1'b0, op_b[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == LAST_BIT) begin
                        product      <= acc_next;
                        result_valid <= 1'b1;
                        state        <= ST_HI_START;
                    end
                end
                ST_HI_START: begin
                    if (tx_ready) begin
                        seen_low <= 1'b0;
                        state    <= ST_HI_WAIT;
                    end
                end
                ST_HI_WAIT: begin
                    if (!tx_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        state <= ST_LO_START;
                    end
                end
                ST_LO_START: begin
                    if (tx_ready) begin
                        seen_low <= 1'b0;
                        state    <= ST_LO_WAIT;
                    end
                end
                ST_LO_WAIT: begin
                    if (!tx_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mult_ctrl.sv
// Self-checking bench for uart_mult_ctrl: table of operand pairs plus
// hand-written sequences for timeout, overrun, TX stall and mid-TX reset.
module tb_uart_mult_ctrl;

    logic        clk = 1'b0;
    logic        uart_reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] product;
    logic        result_valid;
    logic        busy;
    logic        overrun_err;
    logic        timeout_err;

    logic model_ready;  // transmitter model
    logic hold_low;     // forces tx_ready low for stall tests
    assign tx_ready = model_ready && !hold_low;

    always #5 clk = ~clk;

    uart_mult_ctrl #(
        .TIMEOUT_CYCLES(16),
        .MULT_BITS(8)
    ) dut (
        .clk_int     (clk),
        .uart_reset  (uart_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .product     (product),
        .result_valid(result_valid),
        .busy        (busy),
        .overrun_err (overrun_err),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    typedef struct {
        logic [15:0] prod;
        int          due;
    } res_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_tx = 0;
    int         tmo_pulses = 0;
    int         tmo_cyc = -1;
    logic       mon_en = 1'b0;
    res_t       prod_q[$];
    logic [7:0] byte_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Scoreboard: compare every result and every transmitted byte as it appears.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_start) begin
                n_tx++;
                check("tx_start_needs_ready", {31'd0, tx_ready}, 32'd1);
                if (byte_q.size() == 0) begin
                    fail("tx_extra", $sformatf("unexpected tx byte 0x%0h", tx_data));
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, byte_q.pop_front()});
                end
            end
            if (result_valid) begin
                if (prod_q.size() == 0) begin
                    fail("result_extra", $sformatf("unexpected product 0x%0h", product));
                end else begin
                    res_t r;
                    r = prod_q.pop_front();
                    check("product", {16'd0, product}, {16'd0, r.prod});
                    check("result_latency", cyc, r.due);
                end
            end
            if (timeout_err) begin
                tmo_pulses++;
                tmo_cyc = cyc;
                if (result_valid) fail("rv_and_timeout", "result_valid and timeout_err together");
            end
        end
    end

    // Transmitter model: after each start, drop ready for 3 cycles then raise it.
    initial begin
        model_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                #1 model_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 model_ready = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int c);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        c        = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int   c;
        res_t r;
        send_byte(a, c);
        byte_q.push_back(p[15:8]);
        byte_q.push_back(p[7:0]);
        send_byte(b, c);
        r.prod = p;
        r.due  = c + 9;
        prod_q.push_back(r);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy && byte_q.size() == 0 && prod_q.size() == 0) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    function automatic logic [31:0] out_word();
        return {3'd0, tx_start, tx_data, product, result_valid, busy, overrun_err, timeout_err};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   c;
        int   a_cyc;
        int   n0;
        int   bad_start;
        int   bad_data;
        logic seen;

        vecs[0] = '{8'h0C, 8'h0A, 16'h0078};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'h37, 16'h0000};
        vecs[3] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[4] = '{8'h80, 8'h02, 16'h0100};
        vecs[5] = '{8'h0F, 8'h11, 16'h00FF};
        vecs[6] = '{8'hA5, 8'h3C, 16'h26AC};

        uart_reset = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        hold_low   = 1'b0;
        repeat (3) @(posedge clk);
        #1 uart_reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", out_word(), 32'd0);

        // Table-driven operand pairs.
        for (int i = 0; i < 7; i++) begin
            send_pair(vecs[i].a, vecs[i].b, vecs[i].prod);
            wait_idle($sformatf("idle_vec%0d", i));
        end
        check("no_overrun_yet", {31'd0, overrun_err}, 32'd0);

        // Timeout: A only, then silence.
        send_byte(8'h05, a_cyc);
        n0 = tmo_pulses;
        repeat (25) @(negedge clk);
        check("timeout_pulses", tmo_pulses - n0, 1);
        check("timeout_cycle", tmo_cyc, a_cyc + 17);
        check("idle_after_timeout", {31'd0, busy}, 32'd0);
        send_pair(8'h03, 8'h04, 16'h000C);
        wait_idle("idle_after_timeout_pair");

        // B lands on the very cycle the count reaches the limit: accepted.
        send_byte(8'h05, a_cyc);
        byte_q.push_back(8'h00);
        byte_q.push_back(8'h2D);
        n0 = tmo_pulses;
        repeat (14) @(posedge clk);
        send_byte(8'h09, c);
        begin
            res_t r;
            r.prod = 16'h002D;
            r.due  = c + 9;
            prod_q.push_back(r);
        end
        wait_idle("idle_limit_pair");
        check("limit_no_timeout", tmo_pulses - n0, 0);

        // Overrun: third byte during MULT is dropped.
        send_pair(8'h02, 8'h03, 16'h0006);
        send_byte(8'h99, c);
        wait_idle("idle_overrun");
        check("overrun_set", {31'd0, overrun_err}, 32'd1);
        send_pair(8'h10, 8'h10, 16'h0100);
        wait_idle("idle_after_overrun");
        check("overrun_sticky", {31'd0, overrun_err}, 32'd1);

        // TX stall: ready held low across the result.
        n0 = n_tx;
        @(posedge clk);
        #1 hold_low = 1'b1;
        send_pair(8'h02, 8'h03, 16'h0006);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check("stall_result_seen", {31'd0, seen}, 32'd1);
        bad_start = 0;
        bad_data  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start) bad_start++;
            if (tx_data !== 8'h00) bad_data++;
        end
        check("stall_no_start", bad_start, 0);
        check("stall_tx_data", bad_data, 0);
        @(posedge clk);
        #1 hold_low = 1'b0;
        wait_idle("idle_after_stall");
        check("stall_start_count", n_tx - n0, 2);

        // Reset between the two TX bytes.
        n0 = n_tx;
        send_pair(8'h11, 8'h11, 16'h0121);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (n_tx != n0) seen = 1'b1;
        end
        check("midtx_first_start", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1 uart_reset = 1'b1;
        @(posedge clk);
        #1 uart_reset = 1'b0;
        byte_q.delete();
        @(negedge clk);
        check("midtx_reset_outputs", out_word(), 32'd0);
        repeat (20) @(negedge clk);
        check("midtx_no_second_start", n_tx - n0, 1);
        send_pair(8'h07, 8'h06, 16'h002A);
        wait_idle("idle_after_reset_pair");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mult_ctrl.md
Name: uart_mult_ctrl

Overview:
- Command/response controller that sits directly downstream of the UART receiver and upstream of the UART transmitter.
- Consumes received bytes as operand pairs (A then B) and computes the 16-bit product A*B with a sequential shift-add multiplier.
- Returns the product as two bytes (high byte first) through the transmitter's start/ready handshake.

Parameters:
- TIMEOUT_CYCLES, default 1000000: maximum clk_int cycles allowed in WAIT_B before the frame is abandoned. 0 disables the timeout.
- MULT_BITS, default 8: operand width. The design is fixed at 8; any other value is unsupported.

Ports:
- clk_int  input  1  single system clock; all logic is on its rising edge
- uart_reset  input  1  synchronous, active-high reset
- rx_data  input  8  received byte (from the receiver's uart_received_data)
- rx_valid  input  1  one-cycle pulse; rx_data is valid in that cycle
- tx_ready  input  1  high while the transmitter is idle and can accept a byte
- tx_start  output  1  one-cycle request to transmit tx_data
- tx_data  output  8  byte to transmit; held stable from the start pulse until tx_ready falls
- product  output  16  last computed product, held until the next completion
- result_valid  output  1  one-cycle pulse when product updates
- busy  output  1  high in every state except IDLE
- overrun_err  output  1  sticky; a byte arrived while the block could not accept it
- timeout_err  output  1  one-cycle pulse on a WAIT_B timeout

Behaviour:
- Reset (synchronous, uart_reset=1 at the clock edge):
  - state=IDLE.
  - tx_start=0, tx_data=0, product=0, result_valid=0, busy=0, overrun_err=0, timeout_err=0.
  - Operand registers, bit counter and timeout counter are cleared.
  - Reset has priority over everything, including mid-multiply and mid-transmit. An in-flight frame is discarded and no further tx_start is issued.
- IDLE: on rx_valid, latch A=rx_data and go to WAIT_B. The timeout counter is cleared.
- WAIT_B:
  - On rx_valid: latch B, clear the accumulator, counter=0, go to MULT.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES (nonzero): pulse timeout_err for 1 cycle, return to IDLE, discard A.
  - If rx_valid arrives in the same cycle the count reaches the limit, the byte is accepted and there is no timeout.
- MULT:
  - Exactly 8 cycles, one operand bit per cycle, LSB first.
  - If B[i]=1: acc += A<<i. The accumulator is 16 bits and cannot overflow (max 0xFE01).
  - After the 8th cycle: product<=acc, result_valid pulses, go to TX_HI.
- Latency: B's rx_valid in cycle t gives MULT in cycles t+1..t+8, result_valid=1 in cycle t+9, and the earliest tx_start in cycle t+9.
- TX_HI / TX_LO (tx_data = product[15:8] / product[7:0]):
  - START sub-state: tx_data is driven. In the first cycle with tx_ready=1, tx_start=1 for exactly 1 cycle, then go to the WAIT sub-state.
  - WAIT sub-state: wait for tx_ready=0, then for tx_ready=1 again. TX_HI then proceeds to TX_LO START; TX_LO then proceeds to IDLE.
  - tx_ready held low indefinitely stalls the block with no timeout and no error.
  - tx_start is never asserted while tx_ready=0.
  - There is never more than one tx_start per byte.
- Overrun:
  - Any rx_valid in MULT, TX_HI or TX_LO is dropped and sets overrun_err.
  - overrun_err is cleared only by reset.
  - A dropped byte never becomes an A operand.
- result_valid and timeout_err are never high in the same cycle.
- busy=1 in WAIT_B, MULT, TX_HI and TX_LO.

Test Plan:
- Reset, then send bytes 0x0C, 0x0A. Required: result_valid with product=0x0078 exactly 9 cycles after the second rx_valid, then tx_start with tx_data=0x00, then tx_start with 0x78. busy falls after tx_ready returns high.
- Send 0xFF, 0xFF, then 0x00, 0x37. Required: product=0xFE01 with TX bytes 0xFE, 0x01; then product=0x0000 with TX bytes 0x00, 0x00.
- TIMEOUT_CYCLES=16: send 0x05, then nothing for 20 cycles. Required: timeout_err pulses once, 16 cycles into WAIT_B. Then send 0x03, 0x04: product=0x000C (0x05 discarded).
- Send 0x02, 0x03, then a third byte 0x99 during MULT. Required: overrun_err=1 and stays 1; TX bytes are 0x00, 0x06; the next pair 0x10, 0x10 gives 0x0100.
- Hold tx_ready=0 for 50 cycles after result_valid. Required: no tx_start while tx_ready is low, and tx_data stays 0x00. Release tx_ready: tx_start is 1 for exactly 1 cycle.
- Assert uart_reset for 1 cycle between the two TX bytes. Required: the next cycle shows IDLE with all outputs 0 and no second tx_start. A new pair 0x07, 0x06 gives 0x002A.
